gray2_pseudo: RTL and testbench
===============================

GRAY2_PSEUDO -- requirements
Module: gray2_pseudo

Interface
REQ-001 SHALL have ports (clock and reset first):
  VGA_CLK  in  1  pixel clock; all logic on rising edge
  RST  in  1  synchronous reset, active-high
  iGRAY  in  10  grey intensity of current pixel
  iVALID  in  1  qualifies iGRAY, VGA_X, VGA_Y
  VGA_X  in  11  pixel column
  VGA_Y  in  11  pixel row
  PSEUDO_ENABLED  in  1  request pseudo-colour; sampled only at frame start
  CFG_WE  in  1  window register write strobe (single-cycle)
  CFG_ADDR  in  2  0=X0, 1=X1, 2=Y0, 3=Y1
  CFG_DATA  in  11  write data
  CFG_ACK  out  1  one-cycle pulse acknowledging a write
  CFG_PENDING  out  1  shadow window written, not yet committed
  oRED, oGREEN, oBLUE  out  10 each  output colour
  oVALID  out  1  qualifies oRED/oGREEN/oBLUE
REQ-002 SHALL use one clock, VGA_CLK; reset RST is synchronous and active-high.

Function
REQ-003 SHALL register outputs with fixed 2-cycle latency: oVALID(n+2)=iVALID(n); colour(n+2) derived from inputs at n.
REQ-004 SHALL drive oRED/oGREEN/oBLUE = 0 in any cycle where oVALID=0.
REQ-005 Frame start (FS) SHALL be iVALID=1 && VGA_X=0 && VGA_Y=0.
REQ-006 Active settings (enable, X0, X1, Y0, Y1) SHALL change only at FS; FS pixel itself uses newly committed values.
REQ-007 At FS: active enable <= PSEUDO_ENABLED; if pending, active window <= shadow window.
REQ-008 Pixel SHALL be colourised iff active enable && X0<=VGA_X<=X1 && Y0<=VGA_Y<=Y1 (unsigned, inclusive); X0>X1 or Y0>Y1 gives an empty window.
REQ-009 Non-colourised valid pixel: oRED=oGREEN=oBLUE=iGRAY.
REQ-010 Colourised: s=iGRAY[9:8], t={iGRAY[7:0],2'b00}; s=0: R=0,G=t,B=1023; s=1: R=0,G=1023,B=1023-t; s=2: R=t,G=1023,B=0; s=3: R=1023,G=1023-t,B=0.
REQ-011 All map arithmetic SHALL be 10-bit unsigned; no overflow possible (t<=1020).
REQ-012 Config FSM SHALL have states IDLE (CFG_PENDING=0) and PENDING (CFG_PENDING=1).
REQ-013 CFG_WE=1: shadow[CFG_ADDR] <= CFG_DATA; CFG_ACK=1 next cycle; state -> PENDING. Writes accepted in either state, no back-pressure.
REQ-014 PENDING -> IDLE at FS with no CFG_WE in the same cycle.
REQ-015 CFG_WE coincident with FS: commit uses shadow contents before the write; the write lands in shadow; state stays/goes PENDING.
REQ-016 CFG_WE held multiple cycles SHALL count as one write per cycle, with one CFG_ACK per cycle.

Reset
REQ-017 RST=1 SHALL set outputs: colour=0, oVALID=0, CFG_ACK=0, CFG_PENDING=0; FSM=IDLE.
REQ-018 RST SHALL set shadow and active window to X0=0, X1=2047, Y0=0, Y1=2047, and active enable to 0.
REQ-019 Reset mid-frame SHALL flush both pipeline stages; first oVALID no earlier than 2 cycles after first iVALID following reset release.

Configuration
REQ-020 With macro GRAY2PSEUDO_WINDOW_EN defined: window registers, CFG_* ports and FSM present per REQ-008..REQ-016.
REQ-021 Without GRAY2PSEUDO_WINDOW_EN: CFG_WE/CFG_ADDR/CFG_DATA/CFG_ACK/CFG_PENDING absent; every valid pixel colourised iff active enable; enable still committed only at FS; latency unchanged.

Verification
REQ-022 Reset, then FS with PSEUDO_ENABLED=1, iGRAY=0x000 at (0,0) -> 2 cycles later oVALID=1, R=0, G=0, B=1023.
REQ-023 Enabled frame, iGRAY=0x180 -> R=0,G=1023,B=1023-512=511; iGRAY=0x2FF -> R=1020,G=1023,B=0; iGRAY=0x3FF -> R=1023,G=3,B=0.
REQ-024 PSEUDO_ENABLED raised mid-frame at (100,50), iGRAY=0x200 -> output stays grey 512/512/512 until next FS, then colourised.
REQ-025 Write X0=10, X1=20, Y0=5, Y1=5 mid-frame -> CFG_ACK pulse per write, CFG_PENDING=1; after next FS only pixels x 10..20 on row 5 colourised; CFG_PENDING=0.
REQ-026 CFG_WE (addr 0, data 30) in FS cycle with previous shadow X0=10 -> frame uses X0=10; CFG_PENDING stays 1; next FS commits X0=30.
REQ-027 Assert RST with pixels in flight -> oVALID=0 and colour=0 the cycle after; defaults restored; no stale pixel emerges after release.

Source files
------------

// File: rtl/gray2_pseudo.sv
// gray2_pseudo: grey-to-pseudo-colour pixel mapper with 2-cycle latency; optional window via GRAY2PSEUDO_WINDOW_EN.
module gray2_pseudo (
  input  logic        VGA_CLK,
  input  logic        RST,
  input  logic [9:0]  iGRAY,
  input  logic        iVALID,
  input  logic [10:0] VGA_X,
  input  logic [10:0] VGA_Y,
  input  logic        PSEUDO_ENABLED,
`ifdef GRAY2PSEUDO_WINDOW_EN
  input  logic        CFG_WE,
  input  logic [1:0]  CFG_ADDR,
  input  logic [10:0] CFG_DATA,
  output logic        CFG_ACK,
  output logic        CFG_PENDING,
`endif
  output logic [9:0]  oRED,
  output logic [9:0]  oGREEN,
  output logic [9:0]  oBLUE,
  output logic        oVALID
);
  logic        fs, en_eff, en_q, en_d, in_win, v1_q, v1_d, v2_q, v2_d;
  logic [1:0]  s;
  logic [9:0]  t, r, g, b;
  logic [29:0] rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  assign fs = iVALID && VGA_X == 11'd0 && VGA_Y == 11'd0;
`ifdef GRAY2PSEUDO_WINDOW_EN
  typedef enum logic {IDLE, PENDING} cfg_state_e;
  localparam logic [3:0][10:0] WIN_RST = {11'h7ff, 11'h0, 11'h7ff, 11'h0};
  cfg_state_e       state_q, state_d;
  logic [3:0][10:0] sh_q, sh_d, win_q, win_d, eff_win;
  logic             ack_q, ack_d;
  always_comb begin
    sh_d = sh_q;
    if (CFG_WE) sh_d[CFG_ADDR] = CFG_DATA;
    // the FS pixel sees the shadow as it stood before any coincident write
    eff_win = (fs && state_q == PENDING) ? sh_q : win_q;
    win_d = fs ? eff_win : win_q;
    state_d = CFG_WE ? PENDING : fs ? IDLE : state_q;
    ack_d = CFG_WE;
    in_win = VGA_X >= eff_win[0] && VGA_X <= eff_win[1] && VGA_Y >= eff_win[2] && VGA_Y <= eff_win[3];
  end
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sh_q <= WIN_RST;
      win_q <= WIN_RST;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      win_q <= win_d;
      ack_q <= ack_d;
    end
  end
  assign CFG_ACK = ack_q;
  assign CFG_PENDING = state_q == PENDING;
`else
  assign in_win = 1'b1;
`endif
  always_comb begin
    en_eff = fs ? PSEUDO_ENABLED : en_q;
    en_d = en_eff;
    s = iGRAY[9:8];
    t = {iGRAY[7:0], 2'b00};
    r = s[1] ? (s[0] ? 10'd1023 : t) : 10'd0;
    g = s == 2'd0 ? t : s == 2'd3 ? 10'd1023 - t : 10'd1023;
    b = s == 2'd0 ? 10'd1023 : s == 2'd1 ? 10'd1023 - t : 10'd0;
    v1_d = iVALID;
    rgb1_d = !iVALID ? 30'd0 : (en_eff && in_win) ? {r, g, b} : {3{iGRAY}};
    v2_d = v1_q;
    rgb2_d = rgb1_q;
  end
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      en_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      rgb1_q <= 30'd0;
      rgb2_q <= 30'd0;
    end else begin
      en_q <= en_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      rgb1_q <= rgb1_d;
      rgb2_q <= rgb2_d;
    end
  end
  assign {oRED, oGREEN, oBLUE} = rgb2_q;
  assign oVALID = v2_q;
endmodule

// File: tb/tb_gray2_pseudo.sv
// tb_gray2_pseudo: directed-vector bench for gray2_pseudo; window tests run when GRAY2PSEUDO_WINDOW_EN is defined.
module tb_gray2_pseudo;
  logic        VGA_CLK = 1'b0, RST = 1'b1, iVALID = 1'b0, PSEUDO_ENABLED = 1'b0;
  logic [9:0]  iGRAY = '0;
  logic [10:0] VGA_X = '0, VGA_Y = '0;
  logic [9:0]  oRED, oGREEN, oBLUE;
  logic        oVALID;
  int          vecs = 0, errs = 0;
`ifdef GRAY2PSEUDO_WINDOW_EN
  logic        CFG_WE = 1'b0, CFG_ACK, CFG_PENDING;
  logic [1:0]  CFG_ADDR = '0;
  logic [10:0] CFG_DATA = '0;
`endif
  gray2_pseudo dut (
    .VGA_CLK(VGA_CLK), .RST(RST), .iGRAY(iGRAY), .iVALID(iVALID),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .PSEUDO_ENABLED(PSEUDO_ENABLED),
`ifdef GRAY2PSEUDO_WINDOW_EN
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .CFG_ACK(CFG_ACK), .CFG_PENDING(CFG_PENDING),
`endif
    .oRED(oRED), .oGREEN(oGREEN), .oBLUE(oBLUE), .oVALID(oVALID)
  );
  always #5 VGA_CLK = ~VGA_CLK;
  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask
  task automatic cmp(input string tag, input logic [10:0] got, input logic [10:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input int er, input int eg, input int eb);
    cmp({tag, ".v"}, {10'd0, oVALID}, {10'd0, v});
    cmp({tag, ".r"}, {1'b0, oRED}, 11'(er));
    cmp({tag, ".g"}, {1'b0, oGREEN}, 11'(eg));
    cmp({tag, ".b"}, {1'b0, oBLUE}, 11'(eb));
  endtask
  // one valid pixel, one idle cycle, then its result is on the outputs
  task automatic px(input string tag, input int x, input int y, input int gray,
                    input int er, input int eg, input int eb);
    iVALID = 1'b1; VGA_X = 11'(x); VGA_Y = 11'(y); iGRAY = 10'(gray);
    tick();
    cmp({tag, ".lat"}, {10'd0, oVALID}, 11'd0);
    iVALID = 1'b0;
    tick();
    chk_out(tag, 1'b1, er, eg, eb);
  endtask
`ifdef GRAY2PSEUDO_WINDOW_EN
  task automatic cfg_wr(input string tag, input int a, input int d);
    CFG_WE = 1'b1; CFG_ADDR = 2'(a); CFG_DATA = 11'(d);
    tick();
    cmp({tag, ".ack"}, {10'd0, CFG_ACK}, 11'd1);
    CFG_WE = 1'b0;
    tick();
    cmp({tag, ".ack0"}, {10'd0, CFG_ACK}, 11'd0);
    cmp({tag, ".pend"}, {10'd0, CFG_PENDING}, 11'd1);
  endtask
`endif
  initial begin
    tick(); tick();
    chk_out("rst", 1'b0, 0, 0, 0);
`ifdef GRAY2PSEUDO_WINDOW_EN
    cmp("rst.ack", {10'd0, CFG_ACK}, 11'd0);
    cmp("rst.pend", {10'd0, CFG_PENDING}, 11'd0);
`endif
    RST = 1'b0;
    PSEUDO_ENABLED = 1'b1;
    px("fs0", 0, 0, 'h000, 0, 0, 1023);
    px("s1", 1, 0, 'h180, 0, 1023, 511);
    px("s2", 2, 0, 'h2FF, 1020, 1023, 0);
    px("s3", 3, 0, 'h3FF, 1023, 3, 0);
    px("s0", 4, 0, 'h055, 0, 340, 1023);
    PSEUDO_ENABLED = 1'b0;
    px("dis_fs", 0, 0, 'h200, 512, 512, 512);
    PSEUDO_ENABLED = 1'b1;
    px("mid_en", 100, 50, 'h200, 512, 512, 512);
    px("mid_en2", 101, 50, 'h100, 256, 256, 256);
    px("en_fs", 0, 0, 'h200, 0, 1023, 0);
    PSEUDO_ENABLED = 1'b0;
    px("mid_dis", 5, 5, 'h200, 0, 1023, 0);
    PSEUDO_ENABLED = 1'b1;
`ifdef GRAY2PSEUDO_WINDOW_EN
    cfg_wr("wx0", 0, 10);
    cfg_wr("wx1", 1, 20);
    cfg_wr("wy0", 2, 5);
    cfg_wr("wy1", 3, 5);
    px("pre_commit", 15, 9, 'h055, 0, 340, 1023);
    px("win_fs", 0, 0, 'h055, 85, 85, 85);
    cmp("commit.pend", {10'd0, CFG_PENDING}, 11'd0);
    px("win_x0", 10, 5, 'h055, 0, 340, 1023);
    px("win_x1", 20, 5, 'h055, 0, 340, 1023);
    px("win_xhi", 21, 5, 'h055, 85, 85, 85);
    px("win_xlo", 9, 5, 'h055, 85, 85, 85);
    px("win_ylo", 15, 4, 'h055, 85, 85, 85);
    px("win_yhi", 15, 6, 'h055, 85, 85, 85);
    cfg_wr("rew", 0, 10);
    iVALID = 1'b1; VGA_X = '0; VGA_Y = '0; iGRAY = 10'h055;
    CFG_WE = 1'b1; CFG_ADDR = 2'd0; CFG_DATA = 11'd30;
    tick();
    cmp("fswr.ack", {10'd0, CFG_ACK}, 11'd1);
    iVALID = 1'b0; CFG_WE = 1'b0;
    tick();
    chk_out("fswr", 1'b1, 85, 85, 85);
    cmp("fswr.pend", {10'd0, CFG_PENDING}, 11'd1);
    px("old_x0", 10, 5, 'h055, 0, 340, 1023);
    px("fs_new", 0, 0, 'h055, 85, 85, 85);
    cmp("new.pend", {10'd0, CFG_PENDING}, 11'd0);
    px("new_x0", 10, 5, 'h055, 85, 85, 85);
`endif
    iVALID = 1'b1; VGA_X = 11'd10; VGA_Y = 11'd10; iGRAY = 10'h3FF;
    tick();
    RST = 1'b1;
    tick();
    chk_out("mid_rst", 1'b0, 0, 0, 0);
    RST = 1'b0; iVALID = 1'b0;
    tick();
    chk_out("flush1", 1'b0, 0, 0, 0);
    tick();
    chk_out("flush2", 1'b0, 0, 0, 0);
`ifdef GRAY2PSEUDO_WINDOW_EN
    cmp("rst2.pend", {10'd0, CFG_PENDING}, 11'd0);
`endif
    px("en_dflt", 7, 7, 'h3FF, 1023, 1023, 1023);
    px("fs_after", 0, 0, 'h3FF, 1023, 3, 0);
    px("win_dflt", 2047, 2047, 'h180, 0, 1023, 511);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
